countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, meaning clock cycles per centisecond tick (legal range 1..2^20).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port load  input  1  one-cycle request to load the preset fields.
REQ-005 SHALL have port ld_miliseconds  input  9  preset centiseconds.
REQ-006 SHALL have port ld_seconds  input  8  preset seconds.
REQ-007 SHALL have port ld_minutes  input  8  preset minutes.
REQ-008 SHALL have port ld_hours  input  7  preset hours.
REQ-009 SHALL have port start  input  1  run or resume request.
REQ-010 SHALL have port pause  input  1  pause request.
REQ-011 SHALL have port ack  input  1  acknowledge expiry.
REQ-012 SHALL have port miliseconds  output  9  remaining centiseconds, 0..99.
REQ-013 SHALL have port seconds  output  8  remaining seconds, 0..59.
REQ-014 SHALL have port minutes  output  8  remaining minutes, 0..59.
REQ-015 SHALL have port hours  output  7  remaining hours, 0..23.
REQ-016 SHALL have port running  output  1  high while in RUN.
REQ-017 SHALL have port done  output  1  one-cycle pulse on entry to DONE.
REQ-018 SHALL have port alarm  output  1  high while in DONE.

Function
REQ-019 SHALL implement states IDLE, RUN, PAUSED, DONE; all outputs registered.
REQ-020 SHALL, on load in any state, capture the presets clamped per field (ms>99->99, s>59->59, min>59->59, h>23->23), clear the prescaler, and enter IDLE on the next edge.
REQ-021 SHALL give load priority over start, pause and ack in the same cycle.
REQ-022 SHALL, in IDLE on start, enter RUN if the count is nonzero; start on an all-zero count is ignored (stays IDLE).
REQ-023 SHALL, in RUN, advance the prescaler each cycle and issue a tick when it equals TICK_DIV-1, then wrap it to 0.
REQ-024 SHALL, per tick, decrement centiseconds; 0 wraps to 99 with borrow to seconds; seconds 0 wraps to 59 with borrow to minutes; minutes 0 wraps to 59 with borrow to hours.
REQ-025 SHALL, on the edge where a tick makes all four fields zero, enter DONE and assert done for exactly that one cycle.
REQ-026 SHALL, in RUN on pause, enter PAUSED with count and prescaler frozen; pause wins over simultaneous start.
REQ-027 SHALL, in PAUSED on start (pause low), return to RUN resuming the frozen prescaler value.
REQ-028 SHALL, in DONE, hold all fields at zero and alarm high; ack returns to IDLE; start and pause ignored.
REQ-029 SHALL ignore pause in IDLE and DONE and ack outside DONE.
REQ-030 SHALL, with TICK_DIV=1, tick every RUN cycle.

Reset
REQ-031 SHALL, while rst_n low, force IDLE, all time fields 0, prescaler 0, running/done/alarm 0, independent of clk.
REQ-032 SHALL, on rst_n deassertion, remain IDLE until load.
REQ-033 SHALL, on reset mid-RUN, abandon the count with no done pulse.

Verification
REQ-034 SHALL cover: TICK_DIV=1, load 0/0/0/5 ms, start -> running next edge, ms 4,3,2,1,0 on successive cycles, done one cycle with ms=0, alarm held until ack.
REQ-035 SHALL cover: load 0h/1m/0s/0ms, start, one tick -> 0h/0m/59s/99ms.
REQ-036 SHALL cover: load ms=150, s=70, min=99, h=30 -> outputs 99/59/59/23.
REQ-037 SHALL cover: TICK_DIV=4, RUN 6 cycles, pause 10 cycles, resume -> exactly 1 tick before pause, next tick 2 cycles after resume.
REQ-038 SHALL cover: start and pause same cycle in RUN -> PAUSED; load and start same cycle -> IDLE with loaded value.
REQ-039 SHALL cover: rst_n low asynchronously mid-RUN -> all outputs 0 immediately, no done pulse; start on zero count -> stays IDLE.

Source files
------------

// File: rtl/countdown_timer.sv
// Countdown timer holding hh:mm:ss.cc fields, with load/start/pause/ack
// control and a prescaler that sets how many clock cycles make one centisecond.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [8:0] ld_miliseconds,
  input  logic [7:0] ld_seconds,
  input  logic [7:0] ld_minutes,
  input  logic [6:0] ld_hours,
  input  logic       start,
  input  logic       pause,
  input  logic       ack,
  output logic [8:0] miliseconds,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [6:0] hours,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int unsigned PW = 21;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

  logic [8:0] clamp_ms;
  logic [7:0] clamp_s;
  logic [7:0] clamp_m;
  logic [6:0] clamp_h;

  logic [8:0] dec_ms;
  logic [7:0] dec_s;
  logic [7:0] dec_m;
  logic [6:0] dec_h;

  logic tick;
  logic count_zero;
  logic dec_zero;

  always_comb begin
    clamp_ms = (ld_miliseconds > 9'd99) ? 9'd99 : ld_miliseconds;
    clamp_s  = (ld_seconds > 8'd59) ? 8'd59 : ld_seconds;
    clamp_m  = (ld_minutes > 8'd59) ? 8'd59 : ld_minutes;
    clamp_h  = (ld_hours > 7'd23) ? 7'd23 : ld_hours;
  end

  // Mixed-radix decrement: each field borrows from the next only when it is zero.
  always_comb begin
    dec_ms = miliseconds;
    dec_s  = seconds;
    dec_m  = minutes;
    dec_h  = hours;
    if (miliseconds != 9'd0) begin
      dec_ms = miliseconds - 9'd1;
    end else begin
      dec_ms = 9'd99;
      if (seconds != 8'd0) begin
        dec_s = seconds - 8'd1;
      end else begin
        dec_s = 8'd59;
        if (minutes != 8'd0) begin
          dec_m = minutes - 8'd1;
        end else begin
          dec_m = 8'd59;
          dec_h = hours - 7'd1;
        end
      end
    end
  end

  assign tick       = (presc == TICK_LAST);
  assign count_zero = (miliseconds == 9'd0) && (seconds == 8'd0) &&
                      (minutes == 8'd0) && (hours == 7'd0);
  assign dec_zero   = (dec_ms == 9'd0) && (dec_s == 8'd0) &&
                      (dec_m == 8'd0) && (dec_h == 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      presc       <= '0;
      miliseconds <= 9'd0;
      seconds     <= 8'd0;
      minutes     <= 8'd0;
      hours       <= 7'd0;
      running     <= 1'b0;
      done        <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state       <= ST_IDLE;
        presc       <= '0;
        miliseconds <= clamp_ms;
        seconds     <= clamp_s;
        minutes     <= clamp_m;
        hours       <= clamp_h;
        running     <= 1'b0;
        alarm       <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start && !count_zero) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          // Pause freezes both the count and the prescaler phase.
          ST_RUN: begin
            if (pause) begin
              state   <= ST_PAUSED;
              running <= 1'b0;
            end else if (tick) begin
              presc       <= '0;
              miliseconds <= dec_ms;
              seconds     <= dec_s;
              minutes     <= dec_m;
              hours       <= dec_h;
              if (dec_zero) begin
                state   <= ST_DONE;
                running <= 1'b0;
                done    <= 1'b1;
                alarm   <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          ST_PAUSED: begin
            if (start && !pause) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_DONE: begin
            if (ack) begin
              state <= ST_IDLE;
              alarm <= 1'b0;
            end
          end
          default: begin
            state   <= ST_IDLE;
            running <= 1'b0;
            alarm   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
